draw_sprite: RTL and testbench
==============================

DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 Parameter SPR_W, default 100: sprite width in pixels (1..1024).
REQ-002 Parameter SPR_H, default 100: sprite height in pixels (1..1024).
REQ-003 Parameter ADDR_W, default 14: ROM address width; SHALL satisfy 2**ADDR_W >= SPR_W*SPR_H.
REQ-004 Parameter ROM_LAT, default 1: ROM read latency in clk cycles (1..3).
REQ-005 Parameter KEY_EN, default 1: 1 enables transparent colour keying.
REQ-006 Parameter KEY_COLOR, default vga_pkg::SPRITE_KEY_COLOR: the transparent colour.
REQ-007 clk  in  1  system/pixel clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 vga_in  vga_if.in  --  upstream timing (hcount, vcount, hsync, vsync, hblnk, vblnk) and rgb.
REQ-010 vga_out  vga_if.out  --  downstream timing and rgb, with the sprite overlaid.
REQ-011 xpos  in  12  sprite left column, in pixels.
REQ-012 ypos  in  12  sprite top row, in pixels.
REQ-013 mirror  in  1  1 = sprite flipped horizontally.
REQ-014 enable  in  1  1 = sprite drawn; 0 = pass-through.
REQ-015 rgb_address  out  ADDR_W  ROM read address.
REQ-016 rgb_pixel  in  12  ROM data, valid ROM_LAT cycles after its address.

Function
REQ-017 Shadow registers SHALL capture xpos, ypos, mirror and enable on the cycle vga_in.vcount==0 and vga_in.hcount==0. Shadow values SHALL stay constant for the rest of the frame, so the sprite never tears.
REQ-018 Hit is true when both of these hold, using shadow values: hcount in [xs, xs+SPR_W-1] and vcount in [ys, ys+SPR_H-1]. Both ranges are inclusive, giving exactly SPR_W x SPR_H pixels.
REQ-019 Bounds arithmetic SHALL be done at 13 bits, so xs+SPR_W beyond 4095 does not wrap. Pixels past the visible area are clipped naturally by blanking.
REQ-020 col = hcount-xs when mirror is 0, and SPR_W-1-(hcount-xs) when mirror is 1; row = vcount-ys.
REQ-021 rgb_address SHALL be registered: row*SPR_W+col when hit, 0 otherwise.
REQ-022 Total latency L = 1+ROM_LAT cycles, from vga_in to vga_out, for every timing signal and rgb.
REQ-023 hit, shadow enable and vga_in.rgb SHALL be delayed by L cycles in step with the timing signals.
REQ-024 vga_out.rgb SHALL be rgb_pixel when all of these hold: delayed hit is 1, delayed enable is 1, and NOT (KEY_EN and rgb_pixel==KEY_COLOR). Otherwise vga_out.rgb SHALL be the delayed vga_in.rgb.
REQ-025 A sprite partly off the left or top edge is unsupported. Positions are unsigned; xpos=0 and ypos=0 SHALL draw from column 0 and row 0.
REQ-026 A change to any shadowed input mid-frame SHALL take effect only at the next frame-start capture.

Reset
REQ-027 While rst is high, all vga_out fields SHALL be 0 on the next edge. rgb_address, the shadow registers and every pipeline stage SHALL also be 0.
REQ-028 After rst is released, the sprite stays hidden until the first frame-start capture, because shadow enable resets to 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no residual overlay output.

Structure
REQ-030 SPRITE_KEY_COLOR (12'hF0F) SHALL reside in vga_pkg, together with the existing timing constants.
REQ-031 A sub-module delay (parameters WIDTH and DEPTH; synchronous reset to 0) SHALL implement the timing, rgb, hit and enable delay lines.

Verification
REQ-032 Scenario 1, basic draw. SPR_W=SPR_H=4, ROM_LAT=1, ROM data = address. Set xpos=10, ypos=20, enable=1. Required: at hcount 10..13 and vcount 20..23, vga_out.rgb equals row*4+col, 2 cycles later. Pixel (14,20) and pixel (10,24) pass through.
REQ-033 Scenario 2, mirror. Scenario 1 setup with mirror=1. Required: pixel (10,20) fetches address 3 and pixel (13,20) fetches address 0.
REQ-034 Scenario 3, keying. ROM word 5 = 12'hF0F, background = 12'h123. Required: pixel (11,21) outputs 12'h123 with KEY_EN=1, and 12'hF0F with KEY_EN=0.
REQ-035 Scenario 4, tear-free update. Change xpos 10->50 at vcount=22. Required: rows 22..23 still draw at 10, and the next frame draws at 50.
REQ-036 Scenario 5, latency sweep. ROM_LAT=3. Required: all vga_out timing and rgb lag vga_in by exactly 4 cycles, and hsync/vsync edges stay aligned with rgb.
REQ-037 Scenario 6, reset. Assert rst at hcount=12, vcount=21. Required: all outputs are 0 the next cycle, and no sprite appears until after the next frame start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the sprite transparent colour and the packed
// bus type used to carry timing plus rgb through pipelines.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 800;
  localparam int unsigned H_FRONT   = 40;
  localparam int unsigned H_SYNC    = 128;
  localparam int unsigned H_BACK    = 88;
  localparam int unsigned H_TOTAL   = 1056;
  localparam int unsigned V_VISIBLE = 600;
  localparam int unsigned V_FRONT   = 1;
  localparam int unsigned V_SYNC    = 4;
  localparam int unsigned V_BACK    = 23;
  localparam int unsigned V_TOTAL   = 628;

  localparam logic [11:0] SPRITE_KEY_COLOR = 12'hF0F;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing and pixel bundle passed between drawing stages.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-depth shift register with synchronous reset to zero.
module delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/draw_sprite.sv
// Overlays a ROM-backed sprite on the VGA stream; position, mirror and enable
// are latched at frame start so the sprite never tears mid-frame.
module draw_sprite
  import vga_pkg::*;
#(
  parameter int unsigned SPR_W     = 100,
  parameter int unsigned SPR_H     = 100,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned ROM_LAT   = 1,
  parameter bit          KEY_EN    = 1'b1,
  parameter logic [11:0] KEY_COLOR = SPRITE_KEY_COLOR
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 vga_in,
  vga_if.out                vga_out,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              mirror,
  input  logic              enable,
  output logic [ADDR_W-1:0] rgb_address,
  input  logic [11:0]       rgb_pixel
);

  localparam int unsigned L   = 1 + ROM_LAT;
  localparam logic [12:0] W13 = 13'(SPR_W);
  localparam logic [12:0] H13 = 13'(SPR_H);

  logic [11:0] xs, ys;
  logic        mir_s, en_s;
  logic        frame_start;
  logic [11:0] x_cur, y_cur;
  logic        mir_cur, en_cur;

  // The capture pixel itself already uses the new values, so xpos=0/ypos=0
  // draws from the very first pixel of the frame.
  always_comb begin
    frame_start = (vga_in.hcount == '0) && (vga_in.vcount == '0);
    x_cur       = frame_start ? xpos   : xs;
    y_cur       = frame_start ? ypos   : ys;
    mir_cur     = frame_start ? mirror : mir_s;
    en_cur      = frame_start ? enable : en_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs    <= '0;
      ys    <= '0;
      mir_s <= 1'b0;
      en_s  <= 1'b0;
    end else if (frame_start) begin
      xs    <= xpos;
      ys    <= ypos;
      mir_s <= mirror;
      en_s  <= enable;
    end
  end

  logic [12:0]       h13, v13, dh, dv, col;
  logic              hit;
  logic [ADDR_W-1:0] addr;

  // Offsets are only trusted once h/v >= origin, so the 13-bit compare
  // against the sprite size never wraps near 4095.
  always_comb begin
    h13  = {1'b0, vga_in.hcount};
    v13  = {1'b0, vga_in.vcount};
    dh   = h13 - {1'b0, x_cur};
    dv   = v13 - {1'b0, y_cur};
    hit  = (h13 >= {1'b0, x_cur}) && (dh < W13) &&
           (v13 >= {1'b0, y_cur}) && (dv < H13);
    col  = mir_cur ? (W13 - 13'd1 - dh) : dh;
    addr = ADDR_W'(dv) * ADDR_W'(W13) + ADDR_W'(col);
  end

  always_ff @(posedge clk) begin
    if (rst)      rgb_address <= '0;
    else if (hit) rgb_address <= addr;
    else          rgb_address <= '0;
  end

  vga_bus_t bus_in, bus_d;
  logic     hit_d, en_d;

  always_comb begin
    bus_in.hcount = vga_in.hcount;
    bus_in.vcount = vga_in.vcount;
    bus_in.hsync  = vga_in.hsync;
    bus_in.vsync  = vga_in.vsync;
    bus_in.hblnk  = vga_in.hblnk;
    bus_in.vblnk  = vga_in.vblnk;
    bus_in.rgb    = vga_in.rgb;
  end

  delay #(
    .WIDTH($bits(vga_bus_t) + 2),
    .DEPTH(L)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hit, en_cur, bus_in}),
    .dout ({hit_d, en_d, bus_d})
  );

  logic keyed;

  // rgb_pixel arrives in the same cycle as the delayed bus, so the final
  // select is combinational on registered controls; reset forces hit_d low.
  always_comb begin
    keyed = KEY_EN && (rgb_pixel == KEY_COLOR);
  end

  assign vga_out.hcount = bus_d.hcount;
  assign vga_out.vcount = bus_d.vcount;
  assign vga_out.hsync  = bus_d.hsync;
  assign vga_out.vsync  = bus_d.vsync;
  assign vga_out.hblnk  = bus_d.hblnk;
  assign vga_out.vblnk  = bus_d.vblnk;
  assign vga_out.rgb    = (hit_d && en_d && !keyed) ? rgb_pixel : bus_d.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed checks of draw_sprite on a small 80x32 raster with a 4x4 sprite,
// using three instances for ROM latency 1/3 and keying on/off.
module tb_draw_sprite;

  localparam int          H_TOT = 80;
  localparam int          V_TOT = 32;
  localparam logic [11:0] BG    = 12'h123;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mirror, enable;
  logic [3:0]  addr_a, addr_b, addr_c;
  logic [11:0] pix_a, pix_b, pix_c, pix_b1, pix_b2;
  int          hc, vc;
  int          n_tests = 0;
  int          n_fail  = 0;

  vga_if vin ();
  vga_if vout_a ();
  vga_if vout_b ();
  vga_if vout_c ();

  always #5 clk = ~clk;

  draw_sprite #(.SPR_W(4), .SPR_H(4), .ADDR_W(4), .ROM_LAT(1), .KEY_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout_a), .xpos(xpos), .ypos(ypos),
    .mirror(mirror), .enable(enable), .rgb_address(addr_a), .rgb_pixel(pix_a));

  draw_sprite #(.SPR_W(4), .SPR_H(4), .ADDR_W(4), .ROM_LAT(3), .KEY_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout_b), .xpos(xpos), .ypos(ypos),
    .mirror(mirror), .enable(enable), .rgb_address(addr_b), .rgb_pixel(pix_b));

  draw_sprite #(.SPR_W(4), .SPR_H(4), .ADDR_W(4), .ROM_LAT(1), .KEY_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout_c), .xpos(xpos), .ypos(ypos),
    .mirror(mirror), .enable(enable), .rgb_address(addr_c), .rgb_pixel(pix_c));

  // ROM holds its own address, except word 5 which is the key colour.
  function automatic logic [11:0] rom_word(input logic [3:0] a);
    return (a == 4'd5) ? 12'hF0F : {8'h00, a};
  endfunction

  always_ff @(posedge clk) begin
    pix_a  <= rom_word(addr_a);
    pix_c  <= rom_word(addr_c);
    pix_b1 <= rom_word(addr_b);
    pix_b2 <= pix_b1;
    pix_b  <= pix_b2;
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  task automatic drive();
    vin.hcount = 12'(hc);
    vin.vcount = 12'(vc);
    vin.hsync  = (hc >= 68 && hc < 72);
    vin.vsync  = (vc == 29 || vc == 30);
    vin.hblnk  = (hc >= 64);
    vin.vblnk  = (vc >= 28);
    vin.rgb    = BG;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc = (vc == V_TOT - 1) ? 0 : vc + 1;
    end
    drive();
  endtask

  // Advance until the input raster sits at (h,v); output of an L-cycle DUT
  // then shows pixel (h-L,v).
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < 6000) begin
      tick();
      n++;
    end
    if (n >= 6000) check("goto_timeout", {11'd0, (hc == h && vc == v)}, 12'd1);
  endtask

  initial begin
    rst = 1'b1; xpos = 12'd10; ypos = 12'd20; mirror = 1'b0; enable = 1'b1;
    hc = 0; vc = 20;
    drive();
    repeat (6) tick();
    check("rst_hcount", vout_a.hcount, 12'd0);
    check("rst_vcount", vout_a.vcount, 12'd0);
    check("rst_rgb",    vout_a.rgb,    12'd0);
    check("rst_addr",   {8'd0, addr_a}, 12'd0);
    check("rst_b_rgb",  vout_b.rgb,    12'd0);
    rst = 1'b0;

    goto(13, 20); check("hidden_before_capture", vout_a.rgb, BG);

    // frame 1: x=10 y=20, no mirror
    goto(11, 20); check("f1_left_of_sprite", vout_a.rgb, BG);
    goto(12, 20); check("f1_p10_20", vout_a.rgb, 12'd0);
    goto(15, 20); check("f1_p13_20", vout_a.rgb, 12'd3);
    goto(16, 20); check("f1_p14_20_pass", vout_a.rgb, BG);
    goto(13, 21);
    check("f1_keyed_on",  vout_a.rgb, BG);
    check("f1_keyed_off", vout_c.rgb, 12'hF0F);
    check("f1_addr_12_21", {8'd0, addr_a}, 12'd6);
    goto(14, 22); check("f1_p12_22", vout_a.rgb, 12'd10);
    goto(16, 22);
    check("lat3_p12_22", vout_b.rgb, 12'd10);
    check("lat3_hcount", vout_b.hcount, 12'd12);
    check("lat3_vcount", vout_b.vcount, 12'd22);
    goto(20, 22); xpos = 12'd50; mirror = 1'b1;
    goto(15, 23); check("f1_tearfree_p13_23", vout_a.rgb, 12'd15);
    goto(53, 23); check("f1_tearfree_p51_23", vout_a.rgb, BG);
    goto(12, 24); check("f1_p10_24_pass", vout_a.rgb, BG);
    goto(71, 25); check("lat3_hsync_pre", {11'd0, vout_b.hsync}, 12'd0);
    goto(72, 25);
    check("lat3_hsync_edge", {11'd0, vout_b.hsync}, 12'd1);
    check("lat3_hsync_hcnt", vout_b.hcount, 12'd68);
    check("lat1_hsync", {11'd0, vout_a.hsync}, 12'd1);
    goto(3, 29); check("lat3_vsync_pre", {11'd0, vout_b.vsync}, 12'd0);
    goto(4, 29);
    check("lat3_vsync_edge", {11'd0, vout_b.vsync}, 12'd1);
    check("lat3_vsync_vcnt", vout_b.vcount, 12'd29);

    // frame 2: x=50, mirrored
    goto(12, 20); check("f2_old_pos_pass", vout_a.rgb, BG);
    goto(52, 20); check("f2_p50_20_mir", vout_a.rgb, 12'd3);
    goto(55, 22); check("f2_p53_22_mir", vout_a.rgb, 12'd8);
    goto(60, 22); xpos = 12'd10;
    goto(13, 23); check("f2_p11_23_pass", vout_a.rgb, BG);
    goto(53, 23); check("f2_p51_23_mir", vout_a.rgb, 12'd14);

    // frame 3: x=10 mirrored, reset mid-sprite
    goto(11, 20); check("f3_mir_addr_10_20", {8'd0, addr_a}, 12'd3);
    goto(12, 20); check("f3_mir_p10_20", vout_a.rgb, 12'd3);
    goto(15, 20); check("f3_mir_p13_20", vout_a.rgb, 12'd0);
    goto(12, 21);
    rst = 1'b1;
    tick();
    check("mid_rst_hcount", vout_a.hcount, 12'd0);
    check("mid_rst_vcount", vout_a.vcount, 12'd0);
    check("mid_rst_sync",  {8'd0, vout_a.hsync, vout_a.vsync, vout_a.hblnk, vout_a.vblnk}, 12'd0);
    check("mid_rst_rgb",   vout_a.rgb, 12'd0);
    check("mid_rst_addr",  {8'd0, addr_a}, 12'd0);
    rst = 1'b0;
    goto(14, 22); check("after_rst_hidden", vout_a.rgb, BG);

    // frame 4: redrawn after capture, then disabled for frame 5
    goto(12, 20); check("f4_redraw_p10_20", vout_a.rgb, 12'd3);
    goto(20, 20); enable = 1'b0;
    goto(15, 21); check("f4_still_on_p13_21", vout_a.rgb, 12'd4);
    goto(12, 20); check("f5_disabled", vout_a.rgb, BG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
